// File: rtl/cra_sequencer.sv
// Control sequencer for a switch-driven carry-ripple accumulator: loads B from SW or
// performs one B <= SW + B per button press, with a settle delay before capturing the sum.
module cra_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LoadB,
  input  logic        Run,
  input  logic [15:0] SW,
  input  logic [15:0] Sum,
  input  logic        C_out,
  output logic        Ld_B,
  output logic [16:0] to_reg,
  output logic        Busy,
  output logic        Ovf,
  output logic [7:0]  Add_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOADB,
    SETTLE,
    ADD,
    WAIT_REL
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  add_count_q, add_count_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= 4'd0;
      ovf_q        <= 1'b0;
      add_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      ovf_q        <= ovf_d;
      add_count_q  <= add_count_d;
    end
  end

  // Requests are only sampled in IDLE; WAIT_REL turns a held button into a single operation.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    ovf_d        = ovf_q;
    add_count_d  = add_count_q;
    Ld_B         = 1'b0;
    to_reg       = 17'h0;
    unique case (state_q)
      IDLE: begin
        if (LoadB) begin
          state_d = LOADB;
        end else if (Run) begin
          state_d      = SETTLE;
          settle_cnt_d = SETTLE_INIT;
        end
      end
      LOADB: begin
        Ld_B        = 1'b1;
        to_reg      = {1'b0, SW};
        ovf_d       = 1'b0;
        add_count_d = 8'd0;
        state_d     = WAIT_REL;
      end
      SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          state_d = ADD;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      ADD: begin
        Ld_B    = 1'b1;
        to_reg  = {C_out, Sum};
        ovf_d   = ovf_q | C_out;
        if (add_count_q != 8'hFF) begin
          add_count_d = add_count_q + 8'd1;
        end
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!LoadB && !Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q != IDLE);
  assign Ovf       = ovf_q;
  assign Add_count = add_count_q;

endmodule

// File: tb/tb_cra_sequencer.sv
// Scoreboard bench for cra_sequencer: models the external B register and adder, predicts
// every Ld_B pulse (value and cycle) and checks Ovf/Add_count/Busy after each operation.
module tb_cra_sequencer;

  localparam int S = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LoadB;
  logic        Run;
  logic [15:0] SW;
  logic [15:0] Sum;
  logic        C_out;
  logic        Ld_B;
  logic [16:0] to_reg;
  logic        Busy;
  logic        Ovf;
  logic [7:0]  Add_count;

  cra_sequencer #(.SETTLE_CYCLES(S)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .LoadB     (LoadB),
    .Run       (Run),
    .SW        (SW),
    .Sum       (Sum),
    .C_out     (C_out),
    .Ld_B      (Ld_B),
    .to_reg    (to_reg),
    .Busy      (Busy),
    .Ovf       (Ovf),
    .Add_count (Add_count)
  );

  always #5 Clk = ~Clk;

  // external B register and adder, as they sit around the sequencer on the board
  logic [16:0] env_b = 17'h0;
  always @(posedge Clk) if (Ld_B) env_b <= to_reg;
  assign {C_out, Sum} = {1'b0, SW} + {1'b0, env_b[15:0]};

  typedef struct {
    logic [16:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          negcnt = 0;
  logic [16:0] model_b = 17'h0;
  logic        model_ovf = 1'b0;
  logic [7:0]  model_cnt = 8'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic rn, input logic [15:0] sw);
    @(negedge Clk);
    #1;
    LoadB = ld;
    Run   = rn;
    SW    = sw;
  endtask

  task automatic pushExp(input logic [16:0] val, input int cyc);
    exp_t e;
    e.val = val;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic modelAdd(input logic [15:0] sw);
    logic [16:0] t;
    t = {1'b0, sw} + {1'b0, model_b[15:0]};
    model_b   = t;
    model_ovf = model_ovf | t[16];
    if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    pushExp(t, negcnt + 1 + S);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    checkOutput({tag, "_ovf"}, {31'b0, Ovf}, {31'b0, model_ovf});
    checkOutput({tag, "_cnt"}, {24'b0, Add_count}, {24'b0, model_cnt});
  endtask

  task automatic doLoad(input logic [15:0] sw, input int hold, input logic with_run);
    applyStimulus(1'b1, with_run, sw);
    pushExp({1'b0, sw}, negcnt + 1);
    model_b   = {1'b0, sw};
    model_ovf = 1'b0;
    model_cnt = 8'd0;
    @(negedge Clk);
    #1 checkOutput("load_busy", {31'b0, Busy}, 32'd1);
    repeat (hold - 1) @(negedge Clk);
    applyStimulus(1'b0, 1'b0, sw);
    repeat (3) @(negedge Clk);
    #1 checkIdle("load");
  endtask

  task automatic doRun(input logic [15:0] sw, input int hold, input logic poke, input logic full);
    applyStimulus(1'b0, 1'b1, sw);
    modelAdd(sw);
    @(negedge Clk);
    #1;
    if (full) checkOutput("run_busy", {31'b0, Busy}, 32'd1);
    if (poke) LoadB = 1'b1;
    repeat (hold - 1) begin
      @(negedge Clk);
      #1 LoadB = 1'b0;
    end
    applyStimulus(1'b0, 1'b0, sw);
    repeat (S + 3) @(negedge Clk);
    #1;
    if (full) checkIdle("run");
  endtask

  // scoreboard monitor: every Ld_B pulse must match the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      negcnt++;
      if (Ld_B === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_ldb", {31'b0, Ld_B}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("to_reg", {15'b0, to_reg}, {15'b0, e.val});
          checkOutput("ldb_cycle", negcnt, e.cyc);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    LoadB = 1'b0;
    Run   = 1'b0;
    SW    = 16'h0;
    repeat (2) @(negedge Clk);
    #1;
    checkOutput("rst_ldb", {31'b0, Ld_B}, 32'd0);
    checkOutput("rst_toreg", {15'b0, to_reg}, 32'd0);
    checkIdle("rst");
    Reset = 1'b0;

    $display("[TB] load, accumulate");
    doLoad(16'h1234, 3, 1'b0);
    doRun(16'h0001, 10, 1'b0, 1'b1);

    $display("[TB] overflow and sticky flag");
    doLoad(16'hFFFF, 1, 1'b0);
    doRun(16'h0001, 2, 1'b0, 1'b1);
    doRun(16'h0001, 2, 1'b1, 1'b1);
    doRun(16'h8000, 4, 1'b0, 1'b1);
    doLoad(16'h00AA, 2, 1'b0);

    $display("[TB] simultaneous LoadB and Run");
    doLoad(16'h5A5A, 2, 1'b1);

    $display("[TB] saturation");
    for (int i = 0; i < 256; i++) begin
      doRun(16'($urandom), 1, 1'b0, (i % 64) == 63);
    end
    checkIdle("sat");

    $display("[TB] reset during SETTLE with held Run");
    applyStimulus(1'b0, 1'b1, 16'h0003);
    @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    model_ovf = 1'b0;
    model_cnt = 8'd0;
    checkOutput("rst_mid_ldb", {31'b0, Ld_B}, 32'd0);
    checkOutput("rst_mid_toreg", {15'b0, to_reg}, 32'd0);
    checkIdle("rst_mid");
    @(negedge Clk);
    #1 Reset = 1'b0;
    modelAdd(16'h0003);
    repeat (S + 2) @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 16'h0003);
    repeat (S + 3) @(negedge Clk);
    #1 checkIdle("post_rst");

    repeat (10) @(negedge Clk);
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/cra_sequencer.md
CRA_SEQUENCER -- requirements
Module: cra_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles waited after Run detection before the sum is captured; legal range 1-15.
REQ-002 The block SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port LoadB  input  1  active-high request to load SW into the B register; synchronous level from the debounced, pre-inverted button.
REQ-005 The block SHALL have port Run  input  1  active-high request to perform one accumulate (B <= SW + B); synchronous level.
REQ-006 The block SHALL have port SW  input  16  operand A / load value.
REQ-007 The block SHALL have port Sum  input  16  adder sum output (SW + B[15:0]).
REQ-008 The block SHALL have port C_out  input  1  adder carry out.
REQ-009 The block SHALL have port Ld_B  output  1  load enable for the 17-bit B register.
REQ-010 The block SHALL have port to_reg  output  17  data for the B register.
REQ-011 The block SHALL have port Busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port Ovf  output  1  sticky carry-out flag.
REQ-013 The block SHALL have port Add_count  output  8  number of accumulates since the last load.

Function
REQ-014 The FSM SHALL have states IDLE, LOADB, SETTLE, ADD and WAIT_REL.
REQ-015 IDLE: LoadB=1 -> LOADB; else Run=1 -> SETTLE; LoadB has priority when both are high on the same edge.
REQ-016 On entering SETTLE the settle counter SHALL load SETTLE_CYCLES-1 and decrement each cycle; counter=0 -> ADD, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-017 LOADB and ADD SHALL each last exactly one cycle, then -> WAIT_REL.
REQ-018 WAIT_REL SHALL remain until LoadB=0 and Run=0 on the same edge, then -> IDLE, so one press yields exactly one operation.
REQ-019 Ld_B SHALL be a Moore output: 1 only in LOADB or ADD.
REQ-020 to_reg SHALL be {1'b0, SW} in LOADB, {C_out, Sum} in ADD and 17'h0 otherwise.
REQ-021 Sum and C_out SHALL be used only in the ADD cycle; SW changes during SETTLE affect only the value captured in ADD.
REQ-022 Latency: Run seen high at edge k -> Ld_B high in cycle k+SETTLE_CYCLES+1 for one cycle.
REQ-023 LoadB seen high at edge k -> Ld_B high in cycle k+1.
REQ-024 At the edge leaving ADD, Ovf SHALL set if C_out=1; it SHALL stay set until the edge leaving LOADB, which clears it.
REQ-025 Add_count SHALL increment at the edge leaving ADD, saturate at 255 (no wrap) and clear at the edge leaving LOADB.
REQ-026 LoadB or Run asserted during SETTLE, ADD or LOADB SHALL be ignored; no request is queued.
REQ-027 Busy SHALL equal (state != IDLE), combinationally from the state register.

Reset
REQ-028 Reset=1 SHALL immediately (asynchronously) force state=IDLE, settle counter=0, Ovf=0 and Add_count=0, hence Ld_B=0, to_reg=0 and Busy=0.
REQ-029 Reset mid-operation (SETTLE/ADD) SHALL abort with no Ld_B pulse; after release the FSM SHALL wait for a fresh request in IDLE, and a held button starts a new operation.

Verification
REQ-030 Load: SW=16'h1234, LoadB high 3 cycles -> one Ld_B pulse, to_reg=17'h01234, Ovf=0, Add_count=0, Busy high until release.
REQ-031 Accumulate: B=16'h1234, SW=16'h0001, Sum=16'h1235, C_out=0, Run high 10 cycles, SETTLE_CYCLES=2 -> Ld_B exactly once 3 cycles after detection, to_reg=17'h01235, Add_count=1.
REQ-032 Overflow: Sum=16'h0000, C_out=1 on a Run -> to_reg=17'h10000, Ovf=1; a second Run with C_out=0 keeps Ovf=1; LoadB clears Ovf and Add_count.
REQ-033 Simultaneous: LoadB and Run rise on the same edge in IDLE -> LOADB path only, to_reg={0,SW}, Add_count unchanged at 0.
REQ-034 Saturation and reset: 256 Run presses -> Add_count stays 8'hFF; Reset pulsed during SETTLE -> no Ld_B, all outputs 0 within the reset cycle.
